spi_master_mcs: RTL and testbench
=================================

SPI_MASTER_MCS -- requirements
Module: spi_master_mcs

Interface
REQ-001 Parameter DW, default 8, SPI frame data width in bits (2..32).
REQ-002 Parameter DEPTH, default 16, entries per TX and RX FIFO (power of two, >=2).
REQ-003 Parameter NSS, default 4, number of slave-select lines (1..8).
REQ-004 Parameter DIVW, default 8, clock-divider field width.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_wr  in  1  write configuration from cfg_din.
REQ-008 cfg_din  in  DIVW+13  {div[DIVW-1:0], len[5:0], ss_sel[2:0], lsb_first, cpha, cpol} (LSB=cpol).
REQ-009 tx_wr  in  1  push tx_din into TX FIFO.
REQ-010 tx_din  in  DW+3  {rx_en, stop, start, data[DW-1:0]}.
REQ-011 rx_rd  in  1  pop RX FIFO.
REQ-012 rx_dout  out  DW+1  {nodata, data[DW-1:0]}; nodata=1 means RX FIFO was empty.
REQ-013 ack  out  1  one-cycle acknowledge of an accepted access.
REQ-014 busy, tx_full, rx_empty, rx_ovf  out  1 each  status.
REQ-015 spi_sck, spi_mosi  out  1; spi_ss_n  out  NSS, active-low; spi_miso  in  1.

Function
REQ-016 SCK half-period SHALL be div+1 clk cycles; divider counts only while busy.
REQ-017 Frame length SHALL be len bits (1..DW); len=0 or len>DW SHALL be treated as DW; TX data right-aligned in data[len-1:0].
REQ-018 States: IDLE, SHIFT, WAIT, STOP.
REQ-019 IDLE with TX head start=1: pop, load shifter, assert spi_ss_n[ss_sel] on the next cycle, enter SHIFT.
REQ-020 IDLE with TX head start=0: entry SHALL be popped and discarded, no SPI activity.
REQ-021 CPHA=0: MOSI valid from SS assertion, sample on leading edge, shift on trailing edge; CPHA=1: shift on leading edge, sample on trailing edge.
REQ-022 spi_sck SHALL idle at cpol whenever not in SHIFT.
REQ-023 After the last bit's trailing edge: stop=1 -> STOP; else TX non-empty -> load next entry, remain in SHIFT with SS held and no extra SCK gap; else WAIT.
REQ-024 WAIT SHALL hold SS asserted and SCK idle until TX non-empty, then load and enter SHIFT at the next half-period boundary.
REQ-025 STOP SHALL hold SS for one half-period, then deassert all spi_ss_n and enter IDLE.
REQ-026 Shift order: lsb_first=0 MSB of data[len-1:0] first; lsb_first=1 bit 0 first.
REQ-027 At frame end with rx_en=1, the received len bits (first-received bit at position len-1 if MSB-first, at bit 0 if LSB-first, upper bits zero) SHALL be pushed to RX FIFO.
REQ-028 RX push with RX FIFO full SHALL drop the word and set sticky rx_ovf; rx_ovf cleared only by cfg_wr or rst.
REQ-029 tx_wr with tx_full=1 SHALL be dropped and not acked.
REQ-030 ack SHALL assert exactly one cycle after an accepted cfg_wr, tx_wr, or any rx_rd.
REQ-031 rx_rd: rx_dout valid in the ack cycle; empty FIFO gives {1, zeros}; rx_dout SHALL be {1, zeros} in all non-ack cycles.
REQ-032 cfg_wr while busy SHALL be acked but configuration unchanged (rx_ovf still cleared).
REQ-033 Simultaneous FIFO push and pop SHALL both take effect; occupancy unchanged.
REQ-034 busy SHALL be 1 in SHIFT, WAIT, STOP.

Reset
REQ-035 rst SHALL clear FIFOs, enter IDLE, set cpol=cpha=lsb_first=0, div=0, len=0, ss_sel=0.
REQ-036 After rst: spi_sck=0, spi_mosi=0, spi_ss_n all 1, ack=0, busy=0, rx_empty=1, tx_full=0, rx_ovf=0.
REQ-037 rst mid-frame SHALL deassert SS on the following cycle; partial frame discarded, nothing pushed to RX.

Structure
REQ-038 Package spi_pkg SHALL hold state encoding, cfg_din field offsets, TX entry bit positions.
REQ-039 One sub-module spi_fifo (WIDTH, DEPTH; wr, rd, din, dout, empty, full), instantiated for TX and RX.

Verification
REQ-040 cfg div=1,len=8,mode0, ss_sel=2; push {rx_en,stop,start}=111 data 0xA5, MISO loopback -> ss_n=4'b1011, SCK period 4 clk, MOSI 10100101, rx_dout=0x0A5.
REQ-041 Mode 3, lsb_first=1, len=5, data 0x13 -> MOSI 1,1,0,0,1; RX word 0x13 upper bits 0.
REQ-042 Two entries start-only then stop-only, 2nd pushed mid-frame -> SS continuous, 16 contiguous SCK cycles; late 2nd push -> WAIT, SCK held idle.
REQ-043 DEPTH+1 rx_en frames without reads -> DEPTH words stored, rx_ovf=1; cfg_wr clears it.
REQ-044 rst at bit 3 of a frame -> ss_n all 1 next cycle, rx_empty=1; rx_rd on empty -> ack, rx_dout nodata=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, configuration word layout,
// TX entry control-bit offsets and frame-length normalisation.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int CFG_CPOL  = 0;
  localparam int CFG_CPHA  = 1;
  localparam int CFG_LSB   = 2;
  localparam int CFG_SS    = 3;
  localparam int CFG_SS_W  = 3;
  localparam int CFG_LEN   = 6;
  localparam int CFG_LEN_W = 6;
  localparam int CFG_DIV   = 12;

  // Control bits sit directly above the DW-bit data field of a TX entry.
  localparam int TX_START_OFS = 0;
  localparam int TX_STOP_OFS  = 1;
  localparam int TX_RXEN_OFS  = 2;

  function automatic logic [5:0] eff_len(input logic [5:0] len, input int dw);
    if (len == 6'd0 || int'(len) > dw) return 6'(dw);
    return len;
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_master_mcs.sv
// SPI master with TX/RX FIFOs, per-entry start/stop framing, chained frames
// without SCK gaps, and a sticky RX overflow flag.
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int NSS   = 4,
  parameter int DIVW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [DIVW+12:0] cfg_din,
  input  logic             tx_wr,
  input  logic [DW+2:0]    tx_din,
  input  logic             rx_rd,
  output logic [DW:0]      rx_dout,
  output logic             ack,
  output logic             busy,
  output logic             tx_full,
  output logic             rx_empty,
  output logic             rx_ovf,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic [NSS-1:0]   spi_ss_n,
  input  logic             spi_miso
);
  state_t            state, state_nx;
  logic              cpol, cpha, lsb_first;
  logic [2:0]        ss_sel;
  logic [5:0]        len, len_e, bit_cnt;
  logic [DIVW-1:0]   div, div_cnt;
  logic              half, sck_q, mosi_q, cur_stop, cur_rxen, cur_bit;
  logic [DW-1:0]     sh, rx_sh, rx_nx, load_sh, rx_head;
  logic [DW+2:0]     tx_head;
  logic              tx_empty, tx_push, tx_pop, rx_full, rx_push;
  logic              bnd, lead_edge, trail_edge, frame_end, sample, load, discard;
  logic              unused_cfg;

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DW-1:1]} : {v[DW-2:0], 1'b0};
  endfunction

  assign unused_cfg = cfg_din[DIVW+12];
  assign len_e      = eff_len(len, DW);
  assign bnd        = busy && (div_cnt == div);
  assign lead_edge  = (state == ST_SHIFT) && bnd && !half;
  assign trail_edge = (state == ST_SHIFT) && bnd && half;
  assign frame_end  = trail_edge && (bit_cnt == len_e - 6'd1);
  assign sample     = cpha ? trail_edge : lead_edge;
  assign cur_bit    = lsb_first ? sh[0] : sh[DW-1];
  assign load_sh    = lsb_first ? tx_head[DW-1:0] : (tx_head[DW-1:0] << (DW - int'(len_e)));
  assign tx_push    = tx_wr && !tx_full;
  assign tx_pop     = load || discard;
  assign rx_push    = frame_end && cur_rxen;

  spi_fifo #(.WIDTH(DW+3), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_push), .rd(tx_pop), .din(tx_din),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  spi_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rx_push), .rd(rx_rd), .din(rx_nx),
    .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    discard  = 1'b0;
    case (state)
      ST_IDLE:
        if (!tx_empty) begin
          if (tx_head[DW+TX_START_OFS]) begin
            load     = 1'b1;
            state_nx = ST_SHIFT;
          end else begin
            discard = 1'b1;
          end
        end
      ST_SHIFT:
        if (frame_end) begin
          if (cur_stop)       state_nx = ST_STOP;
          else if (!tx_empty) load     = 1'b1;
          else                state_nx = ST_WAIT;
        end
      ST_WAIT:
        if (bnd && !tx_empty) begin
          load     = 1'b1;
          state_nx = ST_SHIFT;
        end
      ST_STOP:
        if (bnd) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    spi_sck  = sck_q;
    spi_mosi = mosi_q;
    for (int i = 0; i < NSS; i++) spi_ss_n[i] = !(busy && (ss_sel == 3'(i)));
  end

  always_comb begin
    rx_nx = rx_sh;
    if (sample) begin
      if (lsb_first) begin
        for (int i = 0; i < DW; i++) if (6'(i) == bit_cnt) rx_nx[i] = spi_miso;
      end else begin
        rx_nx = {rx_sh[DW-2:0], spi_miso};
      end
    end
  end

  // Configuration is frozen while a transfer is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpol <= 1'b0; cpha <= 1'b0; lsb_first <= 1'b0;
      ss_sel <= '0; len <= '0; div <= '0;
    end else if (cfg_wr && !busy) begin
      cpol      <= cfg_din[CFG_CPOL];
      cpha      <= cfg_din[CFG_CPHA];
      lsb_first <= cfg_din[CFG_LSB];
      ss_sel    <= cfg_din[CFG_SS +: CFG_SS_W];
      len       <= cfg_din[CFG_LEN +: CFG_LEN_W];
      div       <= cfg_din[CFG_DIV +: DIVW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0; half <= 1'b0; bit_cnt <= '0;
      sck_q <= 1'b0; mosi_q <= 1'b0;
    end else begin
      div_cnt <= (!busy || bnd) ? '0 : div_cnt + 1'b1;
      if (state == ST_SHIFT && bnd) sck_q <= ~sck_q;
      else if (state != ST_SHIFT)   sck_q <= cpol;
      if (lead_edge)       half <= 1'b1;
      else if (trail_edge) half <= 1'b0;
      if (trail_edge) bit_cnt <= bit_cnt + 6'd1;
      if (cpha ? lead_edge : (trail_edge && !frame_end)) mosi_q <= cur_bit;
      // A new entry restarts the bit count; with CPHA=0 its first bit drives MOSI immediately.
      if (load) begin
        bit_cnt <= '0;
        half    <= 1'b0;
        if (!cpha) mosi_q <= lsb_first ? load_sh[0] : load_sh[DW-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    rx_sh <= rx_nx;
    if (cpha ? lead_edge : trail_edge) sh <= shift_out(sh, lsb_first);
    if (load) begin
      sh       <= cpha ? load_sh : shift_out(load_sh, lsb_first);
      rx_sh    <= '0;
      cur_stop <= tx_head[DW+TX_STOP_OFS];
      cur_rxen <= tx_head[DW+TX_RXEN_OFS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf  <= 1'b0;
      ack     <= 1'b0;
      rx_dout <= {1'b1, {DW{1'b0}}};
    end else begin
      if (cfg_wr)                           rx_ovf <= 1'b0;
      else if (rx_push && rx_full && !rx_rd) rx_ovf <= 1'b1;
      ack     <= cfg_wr || tx_push || rx_rd;
      rx_dout <= (rx_rd && !rx_empty) ? {1'b0, rx_head} : {1'b1, {DW{1'b0}}};
    end
  end

endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed bench for spi_master_mcs with MOSI looped back to MISO.
module tb_spi_master_mcs;
  localparam int DW = 8, DEPTH = 16, NSS = 4, DIVW = 8;

  logic clk = 1'b0, rst = 1'b1, cfg_wr = 1'b0, tx_wr = 1'b0, rx_rd = 1'b0;
  logic [DIVW+12:0] cfg_din = '0;
  logic [DW+2:0]    tx_din = '0;
  logic [DW:0]      rx_dout;
  logic ack, busy, tx_full, rx_empty, rx_ovf, spi_sck, spi_mosi, spi_miso;
  logic [NSS-1:0]   spi_ss_n;

  int passes = 0, fails = 0, total = 0;
  int cyc = 0;
  int rise_cyc[$];
  logic rise_mosi[$];
  int ss_off[$];
  logic sck_prev = 1'b0;
  logic [NSS-1:0] ss_prev = '1;

  logic a;
  logic [DW:0] d;
  logic [31:0] w;
  int base, ssb, mn, mx;

  assign spi_miso = spi_mosi;
  always #5 clk = ~clk;

  spi_master_mcs #(.DW(DW), .DEPTH(DEPTH), .NSS(NSS), .DIVW(DIVW)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_din(cfg_din),
    .tx_wr(tx_wr), .tx_din(tx_din), .rx_rd(rx_rd), .rx_dout(rx_dout),
    .ack(ack), .busy(busy), .tx_full(tx_full), .rx_empty(rx_empty), .rx_ovf(rx_ovf),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso)
  );

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    sck_prev <= spi_sck;
    ss_prev  <= spi_ss_n;
    if (!sck_prev && spi_sck) begin
      rise_cyc.push_back(cyc);
      rise_mosi.push_back(spi_mosi);
    end
    if (ss_prev != '1 && spi_ss_n == '1) ss_off.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [7:0] dv, input logic [5:0] ln, input logic [2:0] ss,
                     input logic lsb, input logic cph, input logic cpl, output logic ak);
    cfg_din = {1'b0, dv, ln, ss, lsb, cph, cpl};
    cfg_wr  = 1'b1;
    tick();
    ak     = ack;
    cfg_wr = 1'b0;
  endtask

  task automatic push(input logic rxen, input logic stp, input logic sta,
                      input logic [DW-1:0] dat, output logic ak);
    tx_din = {rxen, stp, sta, dat};
    tx_wr  = 1'b1;
    tick();
    ak    = ack;
    tx_wr = 1'b0;
  endtask

  task automatic rd(output logic [DW:0] dd, output logic ak);
    rx_rd = 1'b1;
    tick();
    dd    = rx_dout;
    ak    = ack;
    rx_rd = 1'b0;
  endtask

  task automatic wait_idle();
    tick(3);
    for (int i = 0; i < 3000 && busy; i++) tick();
    check("idle_timeout", 64'(busy), 64'd0);
    tick(2);
  endtask

  task automatic wait_ss();
    for (int i = 0; i < 50 && spi_ss_n == '1; i++) tick();
    check("ss_timeout", 64'(spi_ss_n != '1), 64'd1);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < 2000 && rise_cyc.size() < n; i++) tick();
    check("rise_timeout", 64'(rise_cyc.size() >= n), 64'd1);
  endtask

  task automatic collect(input int b, input int n, output logic [31:0] wv);
    wv = '0;
    for (int i = 0; i < n; i++)
      if (b + i < rise_mosi.size()) wv = {wv[30:0], rise_mosi[b+i]};
  endtask

  task automatic gaps(input int b, input int n, output int lo, output int hi);
    int g;
    lo = 1000;
    hi = 0;
    for (int i = 1; i < n; i++) begin
      if (b + i < rise_cyc.size()) begin
        g = rise_cyc[b+i] - rise_cyc[b+i-1];
        if (g < lo) lo = g;
        if (g > hi) hi = g;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_sck", 64'(spi_sck), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_ss_n", 64'(spi_ss_n), 64'hF);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rx_empty", 64'(rx_empty), 64'd1);
    check("rst_tx_full", 64'(tx_full), 64'd0);
    check("rst_rx_ovf", 64'(rx_ovf), 64'd0);
    check("rst_rx_dout", 64'(rx_dout), 64'h100);
    rst = 1'b0;
    tick();

    // Mode 0, div=1, len=8, ss_sel=2, data 0xA5
    cfg(8'd1, 6'd8, 3'd2, 1'b0, 1'b0, 1'b0, a);
    check("cfg_ack", 64'(a), 64'd1);
    tick();
    check("ack_one_cycle", 64'(ack), 64'd0);
    base = rise_cyc.size();
    push(1'b1, 1'b1, 1'b1, 8'hA5, a);
    check("tx_ack", 64'(a), 64'd1);
    wait_ss();
    check("m0_mosi_at_ss", 64'(spi_mosi), 64'd1);
    check("m0_ss_n", 64'(spi_ss_n), 64'b1011);
    check("m0_sck_idle_at_ss", 64'(spi_sck), 64'd0);
    check("m0_busy", 64'(busy), 64'd1);
    wait_idle();
    check("m0_rises", 64'(rise_cyc.size() - base), 64'd8);
    collect(base, 8, w);
    check("m0_mosi_bits", 64'(w), 64'hA5);
    gaps(base, 8, mn, mx);
    check("m0_period_min", 64'(mn), 64'd4);
    check("m0_period_max", 64'(mx), 64'd4);
    check("m0_ss_release", 64'(spi_ss_n), 64'hF);
    check("m0_rx_nonempty", 64'(rx_empty), 64'd0);
    rd(d, a);
    check("m0_rd_ack", 64'(a), 64'd1);
    check("m0_rx_word", 64'(d), 64'h0A5);
    tick();
    check("m0_rx_dout_idle", 64'(rx_dout), 64'h100);
    check("m0_rx_empty_after", 64'(rx_empty), 64'd1);

    // Mode 3, LSB first, len=5, div=2, data 0x13
    cfg(8'd2, 6'd5, 3'd0, 1'b1, 1'b1, 1'b1, a);
    tick(2);
    check("m3_sck_idle_cpol", 64'(spi_sck), 64'd1);
    base = rise_cyc.size();
    push(1'b1, 1'b1, 1'b1, 8'h13, a);
    wait_idle();
    check("m3_rises", 64'(rise_cyc.size() - base), 64'd5);
    collect(base, 5, w);
    check("m3_mosi_bits", 64'(w), 64'b11001);
    gaps(base, 5, mn, mx);
    check("m3_period_min", 64'(mn), 64'd6);
    check("m3_period_max", 64'(mx), 64'd6);
    rd(d, a);
    check("m3_rx_word", 64'(d), 64'h013);

    // Chained frames: second entry pushed mid-frame
    cfg(8'd1, 6'd8, 3'd1, 1'b0, 1'b0, 1'b0, a);
    tick(2);
    base = rise_cyc.size();
    ssb  = ss_off.size();
    push(1'b0, 1'b0, 1'b1, 8'h3C, a);
    tick(8);
    push(1'b0, 1'b1, 1'b0, 8'hC3, a);
    wait_idle();
    check("chain_rises", 64'(rise_cyc.size() - base), 64'd16);
    collect(base, 16, w);
    check("chain_mosi_bits", 64'(w), 64'h3CC3);
    gaps(base, 16, mn, mx);
    check("chain_gap_min", 64'(mn), 64'd4);
    check("chain_gap_max", 64'(mx), 64'd4);
    check("chain_ss_releases", 64'(ss_off.size() - ssb), 64'd1);
    check("chain_no_rx", 64'(rx_empty), 64'd1);

    // Late second entry: WAIT holds SS with SCK idle
    base = rise_cyc.size();
    ssb  = ss_off.size();
    push(1'b0, 1'b0, 1'b1, 8'h81, a);
    tick(60);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_ss_held", 64'(spi_ss_n), 64'b1101);
    check("wait_sck_idle", 64'(spi_sck), 64'd0);
    check("wait_rises", 64'(rise_cyc.size() - base), 64'd8);
    cfg(8'd1, 6'd8, 3'd1, 1'b0, 1'b0, 1'b1, a);
    check("cfg_busy_ack", 64'(a), 64'd1);
    tick(2);
    check("cfg_busy_ignored", 64'(spi_sck), 64'd0);
    push(1'b0, 1'b1, 1'b0, 8'h7E, a);
    wait_idle();
    check("wait_total_rises", 64'(rise_cyc.size() - base), 64'd16);
    collect(base, 16, w);
    check("wait_mosi_bits", 64'(w), 64'h817E);
    check("wait_ss_releases", 64'(ss_off.size() - ssb), 64'd1);

    // RX overflow after DEPTH+1 frames
    cfg(8'd0, 6'd8, 3'd0, 1'b0, 1'b0, 1'b0, a);
    for (int i = 0; i <= DEPTH; i++) begin
      push(1'b1, 1'b1, 1'b1, 8'(16 + i), a);
      wait_idle();
      if (i == DEPTH - 1) check("ovf_not_yet", 64'(rx_ovf), 64'd0);
    end
    check("ovf_set", 64'(rx_ovf), 64'd1);
    cfg(8'd0, 6'd8, 3'd0, 1'b0, 1'b0, 1'b0, a);
    check("ovf_cleared", 64'(rx_ovf), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(d, a);
      check($sformatf("ovf_word%0d", i), 64'(d), 64'(9'(16 + i)));
    end
    rd(d, a);
    check("ovf_drained", 64'(d), 64'h100);

    // TX full drop, then reset in the middle of a frame
    cfg(8'd3, 6'd8, 3'd3, 1'b0, 1'b0, 1'b0, a);
    base = rise_cyc.size();
    push(1'b1, 1'b0, 1'b1, 8'h55, a);
    tick(2);
    for (int i = 0; i < DEPTH; i++) push(1'b0, 1'b0, 1'b0, 8'(i), a);
    check("tx_full", 64'(tx_full), 64'd1);
    push(1'b0, 1'b0, 1'b0, 8'hFF, a);
    check("tx_full_no_ack", 64'(a), 64'd0);
    wait_rises(base + 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ss_n", 64'(spi_ss_n), 64'hF);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tx_full", 64'(tx_full), 64'd0);
    check("midrst_rx_empty", 64'(rx_empty), 64'd1);
    rd(d, a);
    check("empty_rd_ack", 64'(a), 64'd1);
    check("empty_rd_nodata", 64'(d), 64'h100);
    tick(40);
    check("midrst_no_push", 64'(rx_empty), 64'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
